// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings and default timing constants.
// Imported by the transmitter today and intended for the matching receiver.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 100 MHz system clock at 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 32'd868;
    localparam int unsigned DEFAULT_CNT_BITS     = 32'd10;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the final cycle of
// each bit. Held at zero while clear_i is high so a frame starts on a clean bit.
module fifo_uart_tx_baud_tick
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_BITS     = DEFAULT_CNT_BITS
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(CLKS_PER_BIT - 32'd1);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    // Next count: clear, wrap on the last cycle of a bit, else increment
    always_comb begin
        tick_o = (cnt_q == LAST_CNT);
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO: pops one word per
// frame and sends it LSB first with one start and one stop bit on tx_o.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned WORD_BITS    = 32'd8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_BITS     = DEFAULT_CNT_BITS
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 tx_en_i,
    input  logic [WORD_BITS-1:0] fifo_rdata_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_read_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned IDX_BITS = (WORD_BITS > 32'd1) ? $clog2(WORD_BITS) : 32'd1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORD_BITS - 32'd1);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [WORD_BITS-1:0] shift_q;
    logic [WORD_BITS-1:0] shift_d;
    logic [IDX_BITS-1:0]  bit_idx_q;
    logic [IDX_BITS-1:0]  bit_idx_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 pop_ok;
    logic                 bit_tick;
    logic                 cnt_clear;

    // The counter idles at zero, so the pop edge lands START on count 0
    assign cnt_clear = (state_q == ST_IDLE);

    fifo_uart_tx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_BITS     (CNT_BITS)
    ) u_baud_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .tick_o  (bit_tick)
    );

    // Next-state, line value and pop/done strobes; the pop is also masked by
    // reset so the FIFO never loses a word while this block is held in reset
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        fifo_read_o = 1'b0;
        done_o      = 1'b0;
        pop_ok      = tx_en_i & ~fifo_empty_i & reset_i;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (pop_ok) begin
                    fifo_read_o = 1'b1;
                    shift_d     = fifo_rdata_i;
                    bit_idx_d   = '0;
                    tx_d        = 1'b0;
                    state_d     = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_tick) begin
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = shift_q >> 1'b1;
                        bit_idx_d = bit_idx_q + IDX_BITS'(1);
                        tx_d      = shift_d[0];
                        state_d   = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    done_o = 1'b1;
                    if (pop_ok) begin
                        fifo_read_o = 1'b1;
                        shift_d     = fifo_rdata_i;
                        bit_idx_d   = '0;
                        tx_d        = 1'b0;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces the line idle immediately
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4, WORD_BITS=8
// (40-cycle frames) against a small FIFO model driven from a queue.
module tb_fifo_uart_tx;

    logic       clk;
    logic       reset_i;
    logic       tx_en_i;
    logic [7:0] fifo_rdata_i;
    logic       fifo_empty_i;
    logic       fifo_read_o;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    fifo_uart_tx #(
        .WORD_BITS    (32'd8),
        .CLKS_PER_BIT (32'd4),
        .CNT_BITS     (32'd3)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .tx_en_i      (tx_en_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_read_o  (fifo_read_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] DONE_LAST = 64'h0000_0080_0000_0000;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] fifo_q[$];
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;
    logic       s_tx, s_busy, s_done, s_rd;
    int         pop_cnt = 0;
    int         done_cnt = 0;
    int         rd_on_empty = 0;
    logic [63:0] w_tx, w_done, w_rd;
    int         rec_idx;
    int         busy_low;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] frame_wave(input logic [7:0] b);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       w[i] = 1'b0;
            else if (i < 36) w[i] = b[(i - 4) / 4];
            else             w[i] = 1'b1;
        end
        return w;
    endfunction

    task automatic drive_fifo();
        fifo_empty_i = (fifo_q.size() == 0);
        if (force_en)               fifo_rdata_i = force_val;
        else if (fifo_q.size() > 0) fifo_rdata_i = fifo_q[0];
        else                        fifo_rdata_i = 8'h00;
    endtask

    // One clock: sample on the falling edge, apply the pop after the rising edge
    task automatic cyc();
        @(negedge clk);
        s_tx = tx_o; s_busy = busy_o; s_done = done_o; s_rd = fifo_read_o;
        if (s_rd) pop_cnt++;
        if (s_done) done_cnt++;
        if (s_rd && fifo_empty_i) rd_on_empty++;
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic clr_rec();
        w_tx = '0; w_done = '0; w_rd = '0; rec_idx = 0; busy_low = 0;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            w_tx[rec_idx]   = s_tx;
            w_done[rec_idx] = s_done;
            w_rd[rec_idx]   = s_rd;
            if (!s_busy) busy_low++;
            rec_idx++;
        end
    endtask

    initial begin
        int pops0;
        int dones0;
        int bad_idle;

        // Reset held with a word waiting
        reset_i = 1'b0;
        tx_en_i = 1'b1;
        fifo_q  = '{8'hA5};
        drive_fifo();
        cyc();
        cyc();
        chk("rst_tx", 64'(s_tx), 64'd1);
        chk("rst_busy", 64'(s_busy), 64'd0);
        chk("rst_rd", 64'(s_rd), 64'd0);
        chk("rst_nopop", 64'(pop_cnt), 64'd0);

        reset_i = 1'b1;
        cyc();
        chk("rel_pop", 64'(s_rd), 64'd1);
        clr_rec();
        collect(40);
        chk("a5_wave", w_tx, frame_wave(8'hA5));
        chk("a5_done", w_done, DONE_LAST);
        chk("a5_rd", w_rd, 64'd0);
        chk("a5_pops", 64'(pop_cnt), 64'd1);
        cyc();
        chk("a5_idle_busy", 64'(s_busy), 64'd0);
        chk("a5_idle_tx", 64'(s_tx), 64'd1);

        // Back-to-back frames
        fifo_q = '{8'h00, 8'hFF, 8'h3C};
        drive_fifo();
        pops0 = pop_cnt;
        cyc();
        chk("b2b_pop0", 64'(s_rd), 64'd1);
        clr_rec();
        collect(40);
        chk("b2b_w00", w_tx, frame_wave(8'h00));
        chk("b2b_rd00", w_rd, DONE_LAST);
        chk("b2b_busy00", 64'(busy_low), 64'd0);
        clr_rec();
        collect(40);
        chk("b2b_wff", w_tx, frame_wave(8'hFF));
        chk("b2b_rdff", w_rd, DONE_LAST);
        chk("b2b_busyff", 64'(busy_low), 64'd0);
        clr_rec();
        collect(40);
        chk("b2b_w3c", w_tx, frame_wave(8'h3C));
        chk("b2b_rd3c", w_rd, 64'd0);
        chk("b2b_done3c", w_done, DONE_LAST);
        chk("b2b_busy3c", 64'(busy_low), 64'd0);
        chk("b2b_pops", 64'(pop_cnt - pops0), 64'd3);
        cyc();
        chk("b2b_end_busy", 64'(s_busy), 64'd0);
        chk("b2b_end_tx", 64'(s_tx), 64'd1);

        // Empty FIFO with transmit enabled
        bad_idle = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (s_rd || !s_tx || s_busy) bad_idle++;
        end
        chk("empty_idle", 64'(bad_idle), 64'd0);

        // tx_en_i dropped during DATA bit 3 of the first frame
        fifo_q = '{8'h11, 8'h22};
        drive_fifo();
        cyc();
        chk("en_pop1", 64'(s_rd), 64'd1);
        clr_rec();
        collect(17);
        tx_en_i = 1'b0;
        collect(23);
        chk("en_w11", w_tx, frame_wave(8'h11));
        chk("en_no_pop2", w_rd, 64'd0);
        clr_rec();
        collect(5);
        chk("en_gap_rd", w_rd, 64'd0);
        chk("en_gap_tx", w_tx, 64'h1F);
        tx_en_i = 1'b1;
        cyc();
        chk("en_pop2", 64'(s_rd), 64'd1);
        clr_rec();
        collect(40);
        chk("en_w22", w_tx, frame_wave(8'h22));

        // Asynchronous reset during DATA bit 5
        fifo_q = '{8'h5A, 8'hC3};
        drive_fifo();
        cyc();
        chk("ar_pop", 64'(s_rd), 64'd1);
        clr_rec();
        collect(26);
        chk("ar_partial", w_tx, frame_wave(8'h5A) & 64'h3FF_FFFF);
        #2;
        reset_i = 1'b0;
        #1;
        chk("ar_tx_now", 64'(tx_o), 64'd1);
        chk("ar_busy_now", 64'(busy_o), 64'd0);
        dones0 = done_cnt;
        pops0  = pop_cnt;
        clr_rec();
        collect(20);
        chk("ar_no_done", 64'(done_cnt - dones0), 64'd0);
        chk("ar_no_pop", 64'(pop_cnt - pops0), 64'd0);
        reset_i = 1'b1;
        cyc();
        chk("ar_pop_next", 64'(s_rd), 64'd1);
        clr_rec();
        collect(40);
        chk("ar_wc3", w_tx, frame_wave(8'hC3));
        chk("ar_donec3", w_done, DONE_LAST);

        // Head word changes two cycles after the pop
        fifo_q = '{8'h96, 8'hE7};
        drive_fifo();
        cyc();
        chk("ld_pop", 64'(s_rd), 64'd1);
        clr_rec();
        collect(2);
        force_en  = 1'b1;
        force_val = 8'h4B;
        drive_fifo();
        collect(30);
        force_en = 1'b0;
        drive_fifo();
        collect(8);
        chk("ld_w96", w_tx, frame_wave(8'h96));
        chk("ld_rd", w_rd, DONE_LAST);
        clr_rec();
        collect(40);
        chk("ld_we7", w_tx, frame_wave(8'hE7));
        cyc();
        chk("ld_end_busy", 64'(s_busy), 64'd0);

        chk("rd_on_empty", 64'(rd_on_empty), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
